// File: rtl/split_acc_pipe_pkg.sv
// Shared types and constants for split_acc_pipe: FSM encoding, lane/shift widths,
// and lane saturation limits.
package split_acc_pipe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned ACC_W_DEF = 48;
    localparam int unsigned SEG_DEF   = 2;
    localparam int unsigned CNT_W_DEF = 8;

    function automatic int unsigned lane_width(input int unsigned acc_w, input int unsigned seg);
        return acc_w / seg;
    endfunction

    function automatic int unsigned shift_width(input int unsigned lane_w);
        return (lane_w > 1) ? $clog2(lane_w) : 1;
    endfunction

    // Most positive / most negative two's-complement value of a w-bit lane.
    function automatic logic [127:0] lane_max(input int unsigned w);
        return (128'd1 << (w - 1)) - 128'd1;
    endfunction

    function automatic logic [127:0] lane_min(input int unsigned w);
        return 128'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/split_acc_pipe_if.sv
// Handshake/config bundle for split_acc_pipe; master drives operands and
// config, slave is the accumulator.
interface split_acc_pipe_if #(
    parameter int unsigned ACC_W = 48,
    parameter int unsigned SEG   = 2,
    parameter int unsigned CNT_W = 8
);
    import split_acc_pipe_pkg::*;

    localparam int unsigned SH_W = shift_width(lane_width(ACC_W, SEG));

    logic             start;
    logic             cfg_split;
    logic [CNT_W-1:0] cfg_len;
    logic [SH_W-1:0]  cfg_shift;
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic [SEG-1:0]   out_ovf;
    logic             busy;

    modport master (
        output start, cfg_split, cfg_len, cfg_shift, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, busy
    );

    modport slave (
        input  start, cfg_split, cfg_len, cfg_shift, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf, busy
    );

endinterface

// File: rtl/split_acc_pipe_acc_lane.sv
// One accumulator lane: W-bit adder with carry in/out, signed overflow detect and,
// when SPLIT_ACC_SAT_EN is defined, saturation to the lane limits.
module acc_lane
    import split_acc_pipe_pkg::*;
#(
    parameter int unsigned W = 24
) (
    input  logic [W-1:0] i_acc,
    input  logic [W-1:0] i_opd,
    input  logic         i_cin,
    input  logic         i_sat,
    output logic [W-1:0] o_sum,
    output logic         o_cout,
    output logic         o_ovf
);

    logic [W:0] w_raw;

    always_comb begin
        w_raw  = {1'b0, i_acc} + {1'b0, i_opd} + {{W{1'b0}}, i_cin};
        o_cout = w_raw[W];
        o_ovf  = (i_acc[W-1] == i_opd[W-1]) && (w_raw[W-1] != i_acc[W-1]);
    end

`ifdef SPLIT_ACC_SAT_EN
    localparam logic [W-1:0] LMAX = W'(lane_max(W));
    localparam logic [W-1:0] LMIN = W'(lane_min(W));

    // On overflow both operands share the sign of i_acc, which gives the direction.
    always_comb begin
        o_sum = w_raw[W-1:0];
        if (i_sat && o_ovf) begin
            o_sum = i_acc[W-1] ? LMIN : LMAX;
        end
    end
`else
    logic w_unused_sat;

    always_comb begin
        w_unused_sat = i_sat;
        o_sum        = w_raw[W-1:0];
    end
`endif

endmodule

// File: rtl/split_acc_pipe.sv
// Burst accumulator with split (SEG signed lanes) or unsplit (one ACC_W word) mode,
// sticky overflow and per-lane arithmetic output shift. Option: SPLIT_ACC_SAT_EN.
module split_acc_pipe
    import split_acc_pipe_pkg::*;
#(
    parameter int unsigned ACC_W = 48,
    parameter int unsigned SEG   = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    split_acc_pipe_if.slave  bus
);

    localparam int unsigned LANE_W = lane_width(ACC_W, SEG);
    localparam int unsigned SH_W   = shift_width(LANE_W);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_split;
    logic             r_fin;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_cnt;
    logic [SH_W-1:0]  r_shift;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_out_data;
    logic [SEG-1:0]   r_ovf;

    logic             w_accept;
    logic             w_last;
    logic [ACC_W-1:0] w_lane_sum;
    logic [ACC_W-1:0] w_sum;
    logic [ACC_W-1:0] w_shifted;
    logic [SEG-1:0]   w_lane_ovf;
    logic [SEG-1:0]   w_lane_cout;
    logic [SEG-1:0]   w_lane_cin;
    logic [SEG-1:0]   w_ovf_mask;
    logic             w_unused_cout;

    assign bus.in_ready  = (r_state == ST_ACC) && !r_fin;
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.out_data  = r_out_data;
    assign bus.out_ovf   = r_ovf;
    assign bus.busy      = (r_state != ST_IDLE);

    assign w_accept      = bus.in_valid && bus.in_ready;
    assign w_last        = (r_cnt == r_len - CNT_W'(1));
    assign w_unused_cout = w_lane_cout[SEG-1];
    assign w_ovf_mask    = r_split ? '1 : (SEG'(1) << (SEG - 1));

    // Lanes form one wide ripple adder when unsplit; split mode gates each carry-in to 0.
    for (genvar g = 0; g < SEG; g++) begin : g_lane
        if (g == 0) begin : g_cin0
            assign w_lane_cin[g] = 1'b0;
        end else begin : g_cinn
            assign w_lane_cin[g] = r_split ? 1'b0 : w_lane_cout[g-1];
        end

        acc_lane #(.W(LANE_W)) u_lane (
            .i_acc  (r_acc[g*LANE_W +: LANE_W]),
            .i_opd  (bus.in_data[g*LANE_W +: LANE_W]),
            .i_cin  (w_lane_cin[g]),
            .i_sat  (r_split),
            .o_sum  (w_lane_sum[g*LANE_W +: LANE_W]),
            .o_cout (w_lane_cout[g]),
            .o_ovf  (w_lane_ovf[g])
        );
    end

    always_comb begin
        w_sum = w_lane_sum;
`ifdef SPLIT_ACC_SAT_EN
        // Unsplit saturation spans the whole word, so it cannot live in a single lane.
        if (!r_split && w_lane_ovf[SEG-1]) begin
            w_sum = r_acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
`endif
    end

    always_comb begin
        w_shifted = '0;
        if (r_split) begin
            for (int unsigned i = 0; i < SEG; i++) begin
                w_shifted[i*LANE_W +: LANE_W] = LANE_W'($signed(r_acc[i*LANE_W +: LANE_W]) >>> r_shift);
            end
        end else begin
            w_shifted = ACC_W'($signed(r_acc) >>> r_shift);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.start)     w_state_nxt = ST_ACC;
            ST_ACC:  if (r_fin)         w_state_nxt = ST_DONE;
            ST_DONE: if (bus.out_ready) w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    // r_fin marks the cycle between the last accept and DONE; the output is registered then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_split    <= 1'b0;
            r_fin      <= 1'b0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_acc      <= '0;
            r_out_data <= '0;
            r_ovf      <= '0;
        end else begin
            if (r_state == ST_IDLE && bus.start) begin
                r_split <= bus.cfg_split;
                r_len   <= (bus.cfg_len == '0) ? CNT_W'(1) : bus.cfg_len;
                r_shift <= bus.cfg_shift;
                r_acc   <= '0;
                r_cnt   <= '0;
                r_ovf   <= '0;
                r_fin   <= 1'b0;
            end
            if (w_accept) begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + CNT_W'(1);
                r_ovf <= r_ovf | (w_lane_ovf & w_ovf_mask);
                if (w_last) begin
                    r_fin <= 1'b1;
                end
            end
            if (r_state == ST_ACC && r_fin) begin
                r_out_data <= w_shifted;
                r_fin      <= 1'b0;
            end
        end
    end

endmodule
